// File: rtl/uart_mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio_if
// Description : picorv32 native memory bus as seen by a single peripheral.
//               master : CPU side (drives request, receives completion)
//               slave  : peripheral side (uart_mmio)
//               mem_valid  request valid
//               mem_addr   byte address
//               mem_wdata  write data
//               mem_wstrb  byte strobes, 0 = read
//               mem_ready  one-cycle completion pulse
//               mem_rdata  read data, 0 when mem_ready is low
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_mmio_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/uart_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio
// Description : Memory-mapped front end for the UART FIFO stage. Decodes a
//               16-byte window at BASE_ADDR and turns CPU word accesses into
//               one-cycle transmit / rx_fifo_pop strobes, returns RX data and
//               status, and raises a maskable latched interrupt.
//               Register map: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC DROP_CNT.
// Ports       : clk, rstn          clock, synchronous active-low reset
//               bus (slave)        CPU memory bus
//               irq                irq_en & irq_pending
//               tx_byte/transmit   TX FIFO push data and strobe
//               rx_fifo_pop        RX FIFO pop strobe
//               rx_byte            RX FIFO head (first-word-fall-through)
//               rx_fifo_empty      RX FIFO empty
//               tx_fifo_full       TX FIFO full
//               uart_irq           UART interrupt request
//               uart_busy          UART receiving or transmitting
// Options     : UART_MMIO_DROP_CNT_EN - include the DROP_CNT counter; when
//               undefined, 0xC reads 0 and writes are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic       clk,
  input  logic       rstn,
  uart_mmio_if.slave bus,
  output logic       irq,
  output logic [7:0] tx_byte,
  output logic       transmit,
  output logic       rx_fifo_pop,
  input  logic [7:0] rx_byte,
  input  logic       rx_fifo_empty,
  input  logic       tx_fifo_full,
  input  logic       uart_irq,
  input  logic       uart_busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      state_q, state_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic        transmit_q, transmit_nxt;
  logic        pop_q, pop_nxt;
  logic [7:0]  tx_byte_q, tx_byte_nxt;
  logic        irq_en_q, irq_en_nxt;
  logic        irq_pending_q, irq_pending_nxt;
  logic        tx_ovf_q, tx_ovf_nxt;
  logic        ovf_clr, pend_clr, drop;
  logic        hit, wr;
`ifdef UART_MMIO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_nxt;
  logic        cnt_clr;
`endif

  assign hit = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
  assign wr  = |bus.mem_wstrb;

  always_comb begin
    state_nxt   = IDLE;
    rdata_nxt   = rdata_q;
    transmit_nxt = 1'b0;
    pop_nxt     = 1'b0;
    tx_byte_nxt = tx_byte_q;
    irq_en_nxt  = irq_en_q;
    ovf_clr     = 1'b0;
    pend_clr    = 1'b0;
    drop        = 1'b0;
`ifdef UART_MMIO_DROP_CNT_EN
    cnt_clr     = 1'b0;
`endif
    // All side effects happen in the accepting cycle; RESP only acknowledges.
    if (state_q == IDLE && hit) begin
      state_nxt = RESP;
      rdata_nxt = '0;
      case (bus.mem_addr[3:2])
        2'd0: begin
          if (wr) begin
            if (bus.mem_wstrb[0]) begin
              if (tx_fifo_full) begin
                drop = 1'b1;
              end else begin
                transmit_nxt = 1'b1;
                tx_byte_nxt  = bus.mem_wdata[7:0];
              end
            end
          end else if (!rx_fifo_empty) begin
            rdata_nxt = {1'b1, 23'b0, rx_byte};
            pop_nxt   = 1'b1;
          end
        end
        2'd1: begin
          if (wr) begin
            ovf_clr  = bus.mem_wdata[3];
            pend_clr = bus.mem_wdata[4];
          end else begin
            rdata_nxt = {27'b0, irq_pending_q, tx_ovf_q, uart_busy,
                         tx_fifo_full, rx_fifo_empty};
          end
        end
        2'd2: begin
          if (wr) begin
            if (bus.mem_wstrb[0]) irq_en_nxt = bus.mem_wdata[0];
          end else begin
            rdata_nxt = {31'b0, irq_en_q};
          end
        end
        default: begin
`ifdef UART_MMIO_DROP_CNT_EN
          if (wr) cnt_clr = 1'b1;
          else    rdata_nxt = {16'h0, drop_cnt_q};
`endif
        end
      endcase
    end
    // Set terms are ORed in last so a same-cycle set beats the W1C.
    tx_ovf_nxt      = drop | (tx_ovf_q & ~ovf_clr);
    irq_pending_nxt = uart_irq | (irq_pending_q & ~pend_clr);
`ifdef UART_MMIO_DROP_CNT_EN
    drop_cnt_nxt = drop_cnt_q;
    if (cnt_clr)                              drop_cnt_nxt = '0;
    else if (drop && drop_cnt_q != 16'hFFFF)  drop_cnt_nxt = drop_cnt_q + 16'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      rdata_q       <= '0;
      transmit_q    <= 1'b0;
      pop_q         <= 1'b0;
      tx_byte_q     <= '0;
      irq_en_q      <= 1'b0;
      irq_pending_q <= 1'b0;
      tx_ovf_q      <= 1'b0;
`ifdef UART_MMIO_DROP_CNT_EN
      drop_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_nxt;
      rdata_q       <= rdata_nxt;
      transmit_q    <= transmit_nxt;
      pop_q         <= pop_nxt;
      tx_byte_q     <= tx_byte_nxt;
      irq_en_q      <= irq_en_nxt;
      irq_pending_q <= irq_pending_nxt;
      tx_ovf_q      <= tx_ovf_nxt;
`ifdef UART_MMIO_DROP_CNT_EN
      drop_cnt_q    <= drop_cnt_nxt;
`endif
    end
  end

  // Qualifying with rstn lets a reset that arrives during RESP suppress the
  // acknowledge in that very cycle rather than one edge later.
  assign bus.mem_ready = (state_q == RESP) && rstn;
  assign bus.mem_rdata = bus.mem_ready ? rdata_q : 32'h0;
  assign transmit      = transmit_q;
  assign rx_fifo_pop   = pop_q;
  assign tx_byte       = tx_byte_q;
  assign irq           = irq_en_q & irq_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mmio
// Description : Directed self-checking bench for uart_mmio.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mmio;
  localparam logic [31:0] BASE = 32'h0200_0000;
`ifdef UART_MMIO_DROP_CNT_EN
  localparam logic [31:0] EXP_DROP3 = 32'd3;
`else
  localparam logic [31:0] EXP_DROP3 = 32'd0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       irq, transmit, rx_fifo_pop;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_fifo_empty = 1'b1;
  logic       tx_fifo_full = 1'b0;
  logic       uart_irq = 1'b0;
  logic       uart_busy = 1'b0;

  int total = 0;
  int passed = 0;

  logic [31:0] o_rdata;
  logic        o_ready, o_tx, o_pop, o_irq;
  logic [7:0]  o_txb;

  uart_mmio_if bus ();

  uart_mmio #(.BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus),
    .irq           (irq),
    .tx_byte       (tx_byte),
    .transmit      (transmit),
    .rx_fifo_pop   (rx_fifo_pop),
    .rx_byte       (rx_byte),
    .rx_fifo_empty (rx_fifo_empty),
    .tx_fifo_full  (tx_fifo_full),
    .uart_irq      (uart_irq),
    .uart_busy     (uart_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a request on a negedge; it is sampled on the next posedge and the
  // response is snapshotted 1 time unit later. valid drops during RESP.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    @(posedge clk);
    #1;
    o_ready = bus.mem_ready;
    o_rdata = bus.mem_rdata;
    o_tx    = transmit;
    o_pop   = rx_fifo_pop;
    o_txb   = tx_byte;
    o_irq   = irq;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a);
    access(a, 32'h0, 4'h0);
  endtask

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, bus.mem_ready}, 32'h0);
    check("rst_rdata", bus.mem_rdata, 32'h0);
    check("rst_transmit", {31'b0, transmit}, 32'h0);
    check("rst_pop", {31'b0, rx_fifo_pop}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_tx_byte", {24'b0, tx_byte}, 32'h0);
    rstn = 1'b1;

    // TX push
    access(BASE + 32'h0, 32'h0000_0041, 4'hF);
    check("tx_ready", {31'b0, o_ready}, 32'h1);
    check("tx_transmit", {31'b0, o_tx}, 32'h1);
    check("tx_byte", {24'b0, o_txb}, 32'h41);
    @(posedge clk); #1;
    check("ready_one_cycle", {31'b0, bus.mem_ready}, 32'h0);
    check("transmit_one_cycle", {31'b0, transmit}, 32'h0);

    // Drops while TX full
    tx_fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      access(BASE + 32'h0, 32'h0000_0077, 4'hF);
      check("drop_no_transmit", {31'b0, o_tx}, 32'h0);
      check("drop_ready", {31'b0, o_ready}, 32'h1);
    end
    tx_fifo_full  = 1'b0;
    rx_fifo_empty = 1'b0;
    rx_byte       = 8'h5A;
    rd(BASE + 32'h4);
    check("status_ovf", o_rdata, 32'h0000_0008);
    check("tx_byte_held", {24'b0, o_txb}, 32'h41);
    rd(BASE + 32'hC);
    check("drop_cnt_3", o_rdata, EXP_DROP3);
    access(BASE + 32'h4, 32'h0000_0008, 4'hF);
    rd(BASE + 32'h4);
    check("status_ovf_clr", o_rdata, 32'h0);
    access(BASE + 32'hC, 32'h0, 4'hF);
    rd(BASE + 32'hC);
    check("drop_cnt_clr", o_rdata, 32'h0);

    // RX read
    rd(BASE + 32'h0);
    check("rx_data", o_rdata, 32'h8000_005A);
    check("rx_pop", {31'b0, o_pop}, 32'h1);
    @(posedge clk); #1;
    check("rx_pop_one_cycle", {31'b0, rx_fifo_pop}, 32'h0);
    rx_fifo_empty = 1'b1;
    rd(BASE + 32'h0);
    check("rx_empty_data", o_rdata, 32'h0);
    check("rx_empty_no_pop", {31'b0, o_pop}, 32'h0);

    // Interrupt
    access(BASE + 32'h8, 32'h1, 4'hF);
    rd(BASE + 32'h8);
    check("ctrl_rd", o_rdata, 32'h1);
    @(negedge clk); uart_irq = 1'b1;
    @(posedge clk); #1;
    check("irq_rise", {31'b0, irq}, 32'h1);
    @(negedge clk); uart_irq = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("irq_latched", {31'b0, irq}, 32'h1);
    rd(BASE + 32'h4);
    check("status_pending", o_rdata, 32'h0000_0011);
    uart_irq = 1'b1;
    access(BASE + 32'h4, 32'h0000_0010, 4'hF);
    uart_irq = 1'b0;
    @(posedge clk); #1;
    check("w1c_set_wins", {31'b0, irq}, 32'h1);
    access(BASE + 32'h4, 32'h0000_0010, 4'hF);
    check("w1c_clears_irq", {31'b0, o_irq}, 32'h0);

    // irq_en masking
    access(BASE + 32'h8, 32'h0, 4'hF);
    @(negedge clk); uart_irq = 1'b1;
    @(negedge clk); uart_irq = 1'b0;
    @(posedge clk); #1;
    check("irq_masked", {31'b0, irq}, 32'h0);
    access(BASE + 32'h8, 32'h1, 4'b0010);
    rd(BASE + 32'h8);
    check("ctrl_no_strb0", o_rdata, 32'h0);
    access(BASE + 32'h8, 32'h1, 4'h1);
    check("irq_enable", {31'b0, o_irq}, 32'h1);
    access(BASE + 32'h8, 32'h0, 4'h1);
    check("irq_disable", {31'b0, o_irq}, 32'h0);

    // DATA write without byte-0 strobe
    access(BASE + 32'h0, 32'h0000_0099, 4'b0010);
    check("data_nostrb_ready", {31'b0, o_ready}, 32'h1);
    check("data_nostrb_tx", {31'b0, o_tx}, 32'h0);

`ifdef UART_MMIO_DROP_CNT_EN
    @(negedge clk);
    force dut.drop_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.drop_cnt_q;
`endif
    tx_fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) access(BASE + 32'h0, 32'h0000_0012, 4'hF);
    tx_fifo_full = 1'b0;
    rd(BASE + 32'hC);
`ifdef UART_MMIO_DROP_CNT_EN
    check("drop_cnt_sat", o_rdata, 32'h0000_FFFF);
`else
    check("drop_cnt_absent", o_rdata, 32'h0);
`endif

    // Out-of-window access
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + 32'h10;
    bus.mem_wdata = 32'h55;
    bus.mem_wstrb = 4'hF;
    @(posedge clk); #1;
    check("oow_ready_n1", {31'b0, bus.mem_ready}, 32'h0);
    check("oow_no_tx", {31'b0, transmit}, 32'h0);
    @(posedge clk); #1;
    check("oow_ready_n2", {31'b0, bus.mem_ready}, 32'h0);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;

    // Reset during RESP (irq_en, irq_pending and tx_ovf are set going in)
    access(BASE + 32'h8, 32'h1, 4'h1);
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + 32'h8;
    bus.mem_wstrb = 4'h0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("rst_in_resp_ready", {31'b0, bus.mem_ready}, 32'h0);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_resp_ready2", {31'b0, bus.mem_ready}, 32'h0);
    rstn = 1'b1;
    rd(BASE + 32'h4);
    check("post_rst_status", o_rdata, 32'h0000_0001);
    rd(BASE + 32'h8);
    check("post_rst_ctrl", o_rdata, 32'h0);
    check("post_rst_irq", {31'b0, o_irq}, 32'h0);
    check("post_rst_tx_byte", {24'b0, o_txb}, 32'h0);
    rd(BASE + 32'hC);
    check("post_rst_drop_cnt", o_rdata, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
